// File: rtl/ram_pkg.sv
// Shared definitions for the single-port byte-enable RAM with clear sweep.
//   BYTE_W  : width of one byte lane
//   state_e : controller states (ST_INIT = clear sweep, ST_READY = serving requests)
//   clog2   : ceiling log2, used to size the sweep pointer
package ram_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Storage array with per-byte write enables and a registered read port.
//   clk, rst_n : clock, synchronous active-low reset (clears the read register only)
//   we_i       : per-byte write enable, bit i gates wdata_i byte i
//   re_i       : read enable; rdata_o loads mem[addr_i] on the edge
//   addr_i     : word address shared by read and write
//   wdata_i    : write data
//   rdata_o    : registered read data, holds when re_i is low
module ram_sp_core
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W/BYTE_W-1:0] we_i,
  input  logic                     re_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  localparam int unsigned BE_W = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane writes; the array itself carries no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (we_i[i]) mem[addr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sp_be_init.sv
// Single-port synchronous RAM with byte enables, range checking and a clear sweep.
//   clk, rst_n : clock, synchronous active-low reset (restarts the sweep)
//   ena, wena  : request strobe and direction (1 = write)
//   addr       : word address
//   wdata, be  : write data and byte enables
//   clr        : pulse that starts a clear sweep writing INIT_V to every word
//   rdata      : registered read data, valid when rvalid pulses
//   rvalid     : read data valid pulse
//   busy       : clear sweep in progress
//   err        : pulse for an out-of-range or dropped request
module ram_sp_be_init
  import ram_pkg::*;
#(
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       ADDR_W = 5,
  parameter int unsigned       DEPTH  = (1 << ADDR_W),
  parameter logic [DATA_W-1:0] INIT_V = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     wena,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic                     clr,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned BE_W  = DATA_W / BYTE_W;
  localparam int unsigned PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               busy_q, busy_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;

  logic               in_range;
  logic               accept;
  logic               wr_ok;
  logic               rd_ok;
  logic [BE_W-1:0]    mem_we;
  logic               mem_re;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  // Request qualification, sweep control and storage port muxing.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    mem_we    = '0;
    mem_re    = 1'b0;
    mem_addr  = addr;
    mem_wdata = wdata;

    in_range = (32'(addr) < DEPTH);
    // clr in READY wins over a same-cycle request, which is then dropped.
    accept   = (state_q == ST_READY) && !clr && ena;
    wr_ok    = accept && wena && in_range;
    rd_ok    = accept && !wena && in_range;
    rvalid_d = rd_ok;
    err_d    = ena && !(accept && in_range);

    case (state_q)
      ST_INIT: begin
        mem_addr  = ADDR_W'(ptr_q);
        mem_wdata = INIT_V;
        mem_we    = '1;
        if (clr) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          state_d = ST_READY;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      ST_READY: begin
        mem_we = wr_ok ? be : '0;
        mem_re = rd_ok;
        if (clr) begin
          state_d = ST_INIT;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Controller state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      busy_q   <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  ram_sp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (rdata)
  );

  assign rvalid = rvalid_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule
